// File: rtl/aww_types_pkg.sv
// Types for the memory arbiter control path.
package aww_types_pkg;

  // Arbiter FSM states: idle, or RAM granted to the dcache or the icache.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

  // Width of the grant-cycle counter used for the access timeout.
  localparam int ARB_CNT_W = 5;

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: the machine word and the RAM handshake state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // State reported by the RAM model each cycle.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/memory_arbiter.sv
// Arbitrates a single RAM port between an icache (read only) and a dcache
// (read/write). A grant latches the request so the RAM sees stable
// address/data/op for the whole access; completion, RAM error, timeout or
// requester withdrawal return the arbiter to IDLE.
//
// Handshake: each cache holds its enable high until its wait goes low. A wait
// is low for exactly one cycle (the completing cycle, or the cycle in which an
// error/timeout is reported) and high in every other cycle. Load data is
// ramload passed straight through and is only meaningful in that cycle.
module memory_arbiter
  import cpu_types_pkg::*;
  import aww_types_pkg::*;
#(
  parameter int TIMEOUT   = 16,  // grant cycles without ACCESS before abort (1..32)
  parameter bit DPRIORITY = 1'b1 // 1: dcache fixed priority, 0: round-robin
) (
  input  logic      CLK,
  input  logic      nRST,
  // icache side
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      iwait,
  // dcache side
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output word_t     dload,
  output logic      dwait,
  // RAM side
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  // sticky error flag
  output logic      memerr
);

  // The counter holds 0 in the first grant cycle, so the TIMEOUT-th grant
  // cycle without ACCESS is the one where it shows TIMEOUT-1; the counter
  // would reach TIMEOUT at the end of that cycle, so the abort is taken there.
  localparam logic [ARB_CNT_W-1:0] CNT_LAST = ARB_CNT_W'(TIMEOUT - 1);

  arb_state_t             state_q, state_d;
  word_t                  addr_q, addr_d;
  word_t                  store_q, store_d;
  logic                   wr_q, wr_d;
  logic [ARB_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   memerr_q, memerr_d;
  logic                   prefer_d_q, prefer_d_d; // round-robin: dcache wins a tie
  logic                   d_req;
  logic                   pick_d;
  logic                   grant_en;
  logic                   release_w;

  assign d_req  = dREN | dWEN;
  // With fixed priority the dcache always wins; otherwise it wins a tie only
  // when the icache was the one served last.
  assign pick_d = d_req & (DPRIORITY | ~iREN | prefer_d_q);

  // Load data is a pass-through; the wait signals say when it is valid.
  assign dload  = ramload;
  assign iload  = ramload;
  assign memerr = memerr_q;

  // Next-state, request latching and RAM/cache handshake outputs.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    store_d    = store_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    memerr_d   = memerr_q;
    prefer_d_d = prefer_d_q;
    dwait      = 1'b1;
    iwait      = 1'b1;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = addr_q;
    ramstore   = store_q;
    grant_en   = 1'b0;
    release_w  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d = DGRANT;
          addr_d  = daddr;
          store_d = dstore;
          wr_d    = dWEN;   // a write wins over a simultaneous read
          cnt_d   = '0;
        end else if (iREN) begin
          state_d = IGRANT;
          addr_d  = iaddr;
          store_d = '0;
          wr_d    = 1'b0;
          cnt_d   = '0;
        end
      end

      DGRANT, IGRANT: begin
        ramREN   = ~wr_q;
        ramWEN   = wr_q;
        grant_en = (state_q == DGRANT) ? d_req : iREN;
        cnt_d    = cnt_q + 1'b1;
        if (!grant_en) begin
          // Requester walked away: drop the RAM request, release nothing.
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          release_w = 1'b1;
          state_d   = IDLE;
        end else if (ramstate == ERROR) begin
          release_w = 1'b1;
          memerr_d  = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          release_w = 1'b1;
          memerr_d  = 1'b1;
          state_d   = IDLE;
        end
        if (release_w) begin
          if (state_q == DGRANT) begin
            dwait      = 1'b0;
            prefer_d_d = 1'b0;
          end else begin
            iwait      = 1'b0;
            prefer_d_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and latched request registers; reset abandons any access in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      store_q    <= '0;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      memerr_q   <= 1'b0;
      prefer_d_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      store_q    <= store_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      memerr_q   <= memerr_d;
      prefer_d_q <= prefer_d_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: one fixed-priority instance (f_*) and one
// round-robin instance (r_*) driven by the same stimulus.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  // ---------------- clock / reset ----------------
  logic      CLK = 1'b0;
  logic      nRST;
  always #5 CLK = ~CLK;

  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  ramstate_t ramstate;

  word_t     f_iload, f_dload, f_ramaddr, f_ramstore;
  logic      f_iwait, f_dwait, f_ramREN, f_ramWEN, f_memerr;
  word_t     r_iload, r_dload, r_ramaddr, r_ramstore;
  logic      r_iwait, r_dwait, r_ramREN, r_ramWEN, r_memerr;

  int checks   = 0;
  int failures = 0;

  memory_arbiter #(.TIMEOUT(16), .DPRIORITY(1'b1)) u_fix (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(f_iload), .iwait(f_iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(f_dload), .dwait(f_dwait),
    .ramREN(f_ramREN), .ramWEN(f_ramWEN), .ramaddr(f_ramaddr),
    .ramstore(f_ramstore), .ramload(ramload), .ramstate(ramstate),
    .memerr(f_memerr)
  );

  memory_arbiter #(.TIMEOUT(16), .DPRIORITY(1'b0)) u_rr (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(r_iload), .iwait(r_iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(r_dload), .dwait(r_dwait),
    .ramREN(r_ramREN), .ramWEN(r_ramWEN), .ramaddr(r_ramaddr),
    .ramstore(r_ramstore), .ramload(ramload), .ramstate(ramstate),
    .memerr(r_memerr)
  );

  // ---------------- scoreboard / checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Move to 1 time unit after the next rising edge; inputs are then changed
  // and outputs sampled one more unit later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    ramstate = FREE;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    idle_inputs();
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  // Safety net: the bench has no open-ended waits, but never let it hang.
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    idle_inputs();
    nRST = 1'b0;

    // Reset state with both requests high.
    #2;
    dREN = 1'b1; iREN = 1'b1;
    #1;
    check("rst_ramren", f_ramREN, 0);
    check("rst_ramwen", f_ramWEN, 0);
    check("rst_dwait", f_dwait, 1);
    check("rst_iwait", f_iwait, 1);
    check("rst_memerr", f_memerr, 0);

    // Simultaneous dREN/iREN, ACCESS in the second grant cycle.
    do_reset();
    dREN = 1'b1; iREN = 1'b1; daddr = 32'h40; iaddr = 32'h80; #1;
    check("sim_c0_ramren", f_ramREN, 0);
    check("sim_c0_dwait", f_dwait, 1);
    step(); ramstate = BUSY; #1;
    check("sim_c1_ramren", f_ramREN, 1);
    check("sim_c1_ramaddr", f_ramaddr, 32'h40);
    check("sim_c1_dwait", f_dwait, 1);
    check("sim_c1_iwait", f_iwait, 1);
    step(); ramstate = ACCESS; ramload = 32'h1234_5678; #1;
    check("sim_c2_dwait", f_dwait, 0);
    check("sim_c2_dload", f_dload, 32'h1234_5678);
    check("sim_c2_iwait", f_iwait, 1);
    step(); dREN = 1'b0; ramstate = FREE; #1;
    check("sim_c3_bubble", f_ramREN, 0);
    check("sim_c3_iwait", f_iwait, 1);
    step(); ramstate = ACCESS; ramload = 32'hCAFE_F00D; #1;
    check("sim_c4_ramren", f_ramREN, 1);
    check("sim_c4_ramaddr", f_ramaddr, 32'h80);
    check("sim_c4_iwait", f_iwait, 0);
    check("sim_c4_iload", f_iload, 32'hCAFE_F00D);
    step(); iREN = 1'b0; ramstate = FREE; #1;
    check("sim_c5_ramren", f_ramREN, 0);

    // dcache write; inputs change after the grant to prove they are latched.
    do_reset();
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; #1;
    step(); ramstate = BUSY; daddr = 32'h999; dstore = 32'h5555_AAAA; #1;
    check("wr_c1_ramwen", f_ramWEN, 1);
    check("wr_c1_ramren", f_ramREN, 0);
    check("wr_c1_ramaddr", f_ramaddr, 32'h100);
    check("wr_c1_ramstore", f_ramstore, 32'hDEAD_BEEF);
    check("wr_c1_dwait", f_dwait, 1);
    step(); ramstate = ACCESS; #1;
    check("wr_c2_dwait", f_dwait, 0);
    step(); dWEN = 1'b0; ramstate = FREE; #1;
    check("wr_c3_ramwen", f_ramWEN, 0);
    check("wr_c3_dwait", f_dwait, 1);

    // dREN and dWEN together: the write wins.
    do_reset();
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h104; #1;
    step(); ramstate = BUSY; #1;
    check("rw_ramwen", f_ramWEN, 1);
    check("rw_ramren", f_ramREN, 0);
    dREN = 1'b0; dWEN = 1'b0;

    // Timeout: BUSY for 16 grant cycles.
    do_reset();
    dREN = 1'b1; daddr = 32'h200; ramstate = BUSY; #1;
    for (int k = 1; k <= 16; k++) begin
      step(); #1;
      if (k < 16) begin
        check($sformatf("to_c%0d_dwait", k), f_dwait, 1);
        check($sformatf("to_c%0d_memerr", k), f_memerr, 0);
      end else begin
        check("to_c16_dwait", f_dwait, 0);
        check("to_c16_memerr", f_memerr, 0);
      end
    end
    step(); #1;
    check("to_c17_memerr", f_memerr, 1);
    check("to_c17_idle", f_ramREN, 0);
    check("to_c17_dwait", f_dwait, 1);
    dREN = 1'b0;
    step(); step(); #1;
    check("to_sticky", f_memerr, 1);

    // RAM ERROR: one-cycle release and memerr.
    do_reset();
    check("err_memerr_cleared", f_memerr, 0);
    dREN = 1'b1; daddr = 32'h300; ramstate = BUSY; #1;
    step(); ramstate = ERROR; #1;
    check("err_dwait", f_dwait, 0);
    check("err_memerr_pre", f_memerr, 0);
    step(); dREN = 1'b0; ramstate = FREE; #1;
    check("err_memerr", f_memerr, 1);
    check("err_dwait_after", f_dwait, 1);
    check("err_idle", f_ramREN, 0);

    // Abort: dREN dropped in the second grant cycle.
    do_reset();
    dREN = 1'b1; daddr = 32'h400; ramstate = BUSY; #1;
    step(); #1;
    check("ab_c1_ramren", f_ramREN, 1);
    step(); dREN = 1'b0; #1;
    check("ab_c2_ramren", f_ramREN, 1);
    check("ab_c2_dwait", f_dwait, 1);
    step(); ramstate = ACCESS; #1;
    check("ab_c3_ramren", f_ramREN, 0);
    check("ab_c3_dwait", f_dwait, 1);
    check("ab_c3_memerr", f_memerr, 0);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    dREN = 1'b1; daddr = 32'h500; ramstate = BUSY; #1;
    step(); #1;
    check("ar_pre_ramren", f_ramREN, 1);
    nRST = 1'b0; #1;
    check("ar_ramren", f_ramREN, 0);
    check("ar_dwait", f_dwait, 1);
    dREN = 1'b0;
    step(); nRST = 1'b1;

    // Both requesting, ACCESS every cycle: fixed priority serves D every
    // time; round-robin alternates D, I, D, I.
    do_reset();
    dREN = 1'b1; iREN = 1'b1; daddr = 32'h40; iaddr = 32'h80; ramstate = ACCESS; #1;
    for (int g = 0; g < 4; g++) begin
      step(); #1;
      check($sformatf("rr_g%0d_f_addr", g), f_ramaddr, 32'h40);
      check($sformatf("rr_g%0d_f_dwait", g), f_dwait, 0);
      check($sformatf("rr_g%0d_r_ren", g), r_ramREN, 1);
      if (g % 2 == 0) begin
        check($sformatf("rr_g%0d_r_addr", g), r_ramaddr, 32'h40);
        check($sformatf("rr_g%0d_r_dwait", g), r_dwait, 0);
        check($sformatf("rr_g%0d_r_iwait", g), r_iwait, 1);
      end else begin
        check($sformatf("rr_g%0d_r_addr", g), r_ramaddr, 32'h80);
        check($sformatf("rr_g%0d_r_iwait", g), r_iwait, 0);
        check($sformatf("rr_g%0d_r_dwait", g), r_dwait, 1);
      end
      step(); #1;
      check($sformatf("rr_b%0d_r_ren", g), r_ramREN, 0);
      check($sformatf("rr_b%0d_f_ren", g), f_ramREN, 0);
    end
    idle_inputs();

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
